scan_bus_bridge: RTL and testbench
==================================

Name: scan_bus_bridge

Overview:
- Converts the quasi-static scan-chain shadow fields (static_wen/ren/addr/wdata) into one handshaked transaction on the on-chip register/SRAM bus.
- Triggered by a toggle of the asynchronous scan_id line.
- Returns read data and a ready flag to the scan shadow registers, where a later load_chain captures them.
- Sits between the scan chain block and the address decoder for the FFT control registers (reset 0x00480, start 0x00500, point config 0x00600) and the data SRAM.

Parameters:
- ADDR_W, 20, bus address width
- DATA_W, 32, bus data width
- SYNC_STAGES, 2, flops in the scan_id synchronizer (min 2)
- TIMEOUT_CYCLES, 12, REQ/WAIT cycles before abandoning a transaction (1..255)
- TIMEOUT_DATA, 32'hDEAD_BEEF, static_rdata value returned on timeout

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- scan_id  in  1  asynchronous transaction toggle from scan block
- static_wen  in  1  write request field
- static_ren  in  1  read request field
- static_addr  in  ADDR_W  transaction address
- static_wdata  in  DATA_W  write data
- static_rdata  out  DATA_W  read result to scan shadow
- static_ready  out  1  transaction complete flag to scan shadow
- bus_req  out  1  bus request
- bus_we  out  1  1 = write, 0 = read
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_ack  in  1  single-cycle completion from target
- bus_rdata  in  DATA_W  read data, valid in the bus_ack cycle

Behaviour:
- Clocking and reset: one clock domain (clk); rst_n is asynchronous assert, active low. Release is used as-is: the board-level reset is already synchronized.
- Reset values: static_rdata=0, static_ready=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, FSM=IDLE, pending=0.
- The synchronizer chain and the "last" flop reset to 0.
- Trigger: scan_id passes through SYNC_STAGES flops; toggle = sync_out XOR last.
- Any toggle, rising or falling, is one event.
- The static_* fields are stable for at least 4 clk before the toggle, so they are sampled directly with no extra synchronization.
- FSM states:
  - IDLE: on toggle or pending, clear pending, sample the static fields into internal regs, go to DECODE.
  - DECODE (1 cycle):
    - wen=1, ren=0 -> REQ as a write.
    - wen=0, ren=1 -> clear static_ready, go to REQ as a read.
    - wen=ren=0 -> IDLE, no bus activity, outputs unchanged.
    - wen=ren=1 -> illegal: IDLE, no bus activity, set illegal flag.
  - REQ: bus_req=1 with bus_we/addr/wdata held stable until bus_ack. bus_ack may arrive in the first REQ cycle.
    - On ack, for a read: static_rdata <= bus_rdata, static_ready <= 1.
    - On ack, for a write: static_rdata and static_ready are unchanged.
    - On ack, the next state is IDLE and bus_req drops the following cycle.
  - Timeout: a counter loads on REQ entry and decrements each REQ cycle.
    - If it reaches 0 without ack: deassert bus_req, static_rdata <= TIMEOUT_DATA, static_ready <= 1, set timeout flag, go to IDLE.
    - A late ack while in IDLE is ignored.
- Latency: toggle edge to bus_req is at most SYNC_STAGES+3 clk. Read ack to static_ready=1 is 1 clk. With 2-cycle ack, total is at most 8 clk, inside the 20-cycle window before load_chain.
- Back-to-back:
  - A toggle seen outside IDLE sets pending (one deep). Pending is serviced on return to IDLE using the static fields present then.
  - A toggle while pending is already set is dropped and sets the overflow flag.
- Reset mid-transaction: bus_req drops immediately (asynchronous), everything returns to reset values, and no ack is awaited afterwards.
- Bus rules: bus_req never asserts in two consecutive transactions without at least one idle cycle between them.

Optional Feature:
- Macro SCAN_BRIDGE_STATUS_EN.
- Defined:
  - Adds output port bridge_status [7:0], reset 0.
  - [0] sticky timeout, [1] sticky illegal, [2] sticky overflow.
  - [7:3] count of completed bus transactions, wrapping mod 32.
  - Sticky bits clear only on rst_n, or on a write to address 0x00700 with wdata[0]=1. That write is consumed by the bridge and not issued on the bus.
- Undefined: the port and all flag/counter logic are absent, and address 0x00700 is forwarded to the bus like any other address.

Test Plan:
- Write: wen=1, addr=0x00600, wdata=0x3, toggle scan_id -> bus_req with bus_we=1, bus_addr=0x00600, bus_wdata=0x3 within 5 clk; ack 2 clk later -> bus_req low the next cycle, static_ready unchanged.
- Read: ren=1, addr=0x00002, ack after 2 clk with bus_rdata=0x13579876 -> static_rdata=0x13579876, static_ready=1 within 8 clk of the toggle; static_ready=0 during the transaction.
- Timeout: read addr=0x001FF, bus_ack held 0 -> bus_req high for exactly 12 clk, then static_rdata=0xDEADBEEF, static_ready=1, status[0]=1 when the feature is enabled.
- Illegal: wen=ren=1, toggle -> no bus_req for 30 clk, status[1]=1.
- Back-to-back: two toggles 3 clk apart with ack stalled 6 clk -> two bus_req pulses with a gap of at least 1 clk; a third toggle during stall -> dropped, status[2]=1.
- Reset mid-transaction: assert rst_n=0 during REQ -> bus_req=0 asynchronously, all outputs return to reset values, no transaction after release until a new toggle.

Source files
------------

// File: rtl/scan_bus_bridge.sv
// Purpose: turns a scan_id toggle plus the quasi-static static_* shadow fields into one bus transaction.
// Latency: toggle edge to bus_req within SYNC_STAGES+3 clk; read ack to static_ready one clk.
// Backpressure: bus_req held until bus_ack or TIMEOUT_CYCLES expire; one extra toggle queues as pending, later ones drop.
// Ports: clk/rst_n; scan_id and static_wen/ren/addr/wdata in; static_rdata/static_ready out;
//        bus_req/bus_we/bus_addr/bus_wdata out, bus_ack/bus_rdata in.
// Option: define SCAN_BRIDGE_STATUS_EN to add bridge_status[7:0] (sticky timeout/illegal/overflow,
//         completed-transaction count) and a bridge-local clear register at 0x00700.
module scan_bus_bridge #(
  parameter int                ADDR_W         = 20,
  parameter int                DATA_W         = 32,
  parameter int                SYNC_STAGES    = 2,
  parameter int                TIMEOUT_CYCLES = 12,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_id,
  input  logic              static_wen,
  input  logic              static_ren,
  input  logic [ADDR_W-1:0] static_addr,
  input  logic [DATA_W-1:0] static_wdata,
  output logic [DATA_W-1:0] static_rdata,
  output logic              static_ready,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
`ifdef SCAN_BRIDGE_STATUS_EN
  ,
  output logic [7:0]        bridge_status
`endif
);

  typedef enum logic [1:0] {IDLE, DECODE, REQ} state_e;

  state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                last_q;
  logic                toggle;
  logic                consume;
  logic                pending_q, pending_d;
  logic                wen_q, wen_d, ren_q, ren_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;

  // scan_id is fully asynchronous; either edge is one event once it leaves the synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], scan_id};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign toggle = sync_q[SYNC_STAGES-1] ^ last_q;

`ifdef SCAN_BRIDGE_STATUS_EN
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(20'h00700);
  // A clearing write to the status address is absorbed here and never reaches the bus.
  assign consume = wen_q && !ren_q && (addr_q == STATUS_ADDR) && wdata_q[0];
`else
  assign consume = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    wen_d       = wen_q;
    ren_d       = ren_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    ready_d     = ready_q;

    // One-deep queue for toggles that arrive while a transaction is in flight.
    if (toggle && (state_q != IDLE) && !pending_q)
      pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (toggle || pending_q) begin
          // A fresh toggle landing on the cycle a pending one is serviced stays queued.
          pending_d = pending_q && toggle;
          wen_d     = static_wen;
          ren_d     = static_ren;
          addr_d    = static_addr;
          wdata_d   = static_wdata;
          state_d   = DECODE;
        end
      end
      DECODE: begin
        state_d = IDLE;
        if ((wen_q ^ ren_q) && !consume) begin
          state_d     = REQ;
          req_d       = 1'b1;
          we_d        = wen_q;
          bus_addr_d  = addr_q;
          bus_wdata_d = wdata_q;
          cnt_d       = 8'(TIMEOUT_CYCLES);
          if (ren_q)
            ready_d = 1'b0;
        end
      end
      REQ: begin
        if (bus_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
          if (!we_q) begin
            rdata_d = bus_rdata;
            ready_d = 1'b1;
          end
        end else if (cnt_q == 8'd1) begin
          // Last allowed cycle without an ack: abandon and report the timeout pattern.
          req_d   = 1'b0;
          rdata_d = TIMEOUT_DATA;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
    end
  end

  assign bus_req      = req_q;
  assign bus_we       = we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign static_rdata = rdata_q;
  assign static_ready = ready_q;

`ifdef SCAN_BRIDGE_STATUS_EN
  logic [2:0] sticky_q;
  logic [4:0] done_cnt_q;
  logic       ev_timeout, ev_illegal, ev_overflow, ev_done, ev_clear;

  assign ev_timeout  = (state_q == REQ) && !bus_ack && (cnt_q == 8'd1);
  assign ev_done     = (state_q == REQ) && bus_ack;
  assign ev_illegal  = (state_q == DECODE) && wen_q && ren_q;
  assign ev_clear    = (state_q == DECODE) && consume;
  assign ev_overflow = toggle && (state_q != IDLE) && pending_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q   <= '0;
      done_cnt_q <= '0;
    end else begin
      sticky_q <= (ev_clear ? 3'b000 : sticky_q) | {ev_overflow, ev_illegal, ev_timeout};
      if (ev_done)
        done_cnt_q <= done_cnt_q + 5'd1;
    end
  end

  assign bridge_status = {done_cnt_q, sticky_q};
`endif

endmodule

// File: tb/tb_scan_bus_bridge.sv
`timescale 1ns/1ps
module tb_scan_bus_bridge;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int TO = 12;
  localparam logic [DW-1:0] TO_DATA = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          scan_id = 1'b0;
  logic          static_wen = 1'b0;
  logic          static_ren = 1'b0;
  logic [AW-1:0] static_addr = '0;
  logic [DW-1:0] static_wdata = '0;
  logic [DW-1:0] static_rdata;
  logic          static_ready;
  logic          bus_req, bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack = 1'b0;
  logic [DW-1:0] bus_rdata = '0;
`ifdef SCAN_BRIDGE_STATUS_EN
  logic [7:0]    bridge_status;
`endif

  scan_bus_bridge dut (
    .clk(clk), .rst_n(rst_n), .scan_id(scan_id),
`ifdef SCAN_BRIDGE_STATUS_EN
    .bridge_status(bridge_status),
`endif
    .static_wen(static_wen), .static_ren(static_ren),
    .static_addr(static_addr), .static_wdata(static_wdata),
    .static_rdata(static_rdata), .static_ready(static_ready),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: transaction-level view of what the scan shadow should hold.
  logic [DW-1:0] exp_rdata = '0;
  logic          exp_ready = 1'b0;
  logic          st_to = 1'b0, st_il = 1'b0, st_ov = 1'b0;
  logic [4:0]    st_cnt = '0;

  // Bus target: acks on the (rsp_delay+1)th cycle of a request, logs what it accepted.
  int            rsp_delay = 0;
  logic [DW-1:0] rsp_data = '0;
  int            req_age = 0;
  int            obs_acks = 0;
  logic          obs_we = 1'b0;
  logic [AW-1:0] obs_addr = '0;
  logic [DW-1:0] obs_wdata = '0;

  initial begin
    forever begin
      @(negedge clk);
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      if (bus_req) begin
        if (req_age == rsp_delay) begin
          bus_ack   = 1'b1;
          bus_rdata = rsp_data;
          obs_acks++;
          obs_we    = bus_we;
          obs_addr  = bus_addr;
          obs_wdata = bus_wdata;
        end
        req_age++;
      end else begin
        req_age = 0;
      end
    end
  end

  // Request pulse monitor.
  int   pulses = 0, cur_len = 0, last_len = 0;
  logic req_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (bus_req) begin
        if (!req_prev) pulses++;
        cur_len++;
      end else begin
        if (req_prev) last_len = cur_len;
        cur_len = 0;
      end
      req_prev = bus_req;
    end
  end

  task automatic chk_status(input string tag);
`ifdef SCAN_BRIDGE_STATUS_EN
    chk({tag, "_status"}, bridge_status, {st_cnt, st_ov, st_il, st_to});
`endif
  endtask

  task automatic do_txn(input string tag, input logic w, input logic r,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int dly, input logic [DW-1:0] rd, output int rdy_cyc);
    logic legal, consume, tmo, seen, was_low;
    int   p0, a0, lat, exp_len;
    legal   = w ^ r;
    consume = 1'b0;
`ifdef SCAN_BRIDGE_STATUS_EN
    consume = w && !r && (a == 20'h00700) && d[0];
`endif
    tmo     = legal && !consume && (dly >= TO);
    exp_len = tmo ? TO : dly + 1;
    static_wen = w; static_ren = r; static_addr = a; static_wdata = d;
    rsp_delay = dly; rsp_data = rd;
    p0 = pulses; a0 = obs_acks; seen = 1'b0; lat = 0; rdy_cyc = 0; was_low = 1'b0;
    repeat (4) @(negedge clk);
    scan_id = ~scan_id;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus_req && !seen) begin
        seen = 1'b1;
        lat  = i;
        chk({tag, "_we"}, bus_we, w);
        chk({tag, "_addr"}, bus_addr, a);
        chk({tag, "_wdata"}, bus_wdata, d);
        if (r) chk({tag, "_rdy_low"}, static_ready, 1'b0);
      end
      if (!static_ready) was_low = 1'b1;
      else if (was_low && rdy_cyc == 0) rdy_cyc = i;
    end
    if (legal && !consume && (r || tmo)) begin
      exp_ready = 1'b1;
      exp_rdata = tmo ? TO_DATA : rd;
    end
    if (consume) begin st_to = 1'b0; st_il = 1'b0; st_ov = 1'b0; end
    if (tmo) st_to = 1'b1;
    if (w && r) st_il = 1'b1;
    if (legal && !consume && !tmo) st_cnt = st_cnt + 5'd1;
    chk({tag, "_pulses"}, pulses - p0, (legal && !consume) ? 1 : 0);
    if (legal && !consume) begin
      chk({tag, "_lat_le5"}, (lat >= 1 && lat <= 5), 1'b1);
      chk({tag, "_len"}, last_len, exp_len);
    end
    chk({tag, "_acks"}, obs_acks - a0, (legal && !consume && !tmo) ? 1 : 0);
    if (legal && !consume && !tmo)
      chk({tag, "_ack_fields"}, {obs_we, obs_addr, obs_wdata}, {w, a, d});
    chk({tag, "_rdata"}, static_rdata, exp_rdata);
    chk({tag, "_ready"}, static_ready, exp_ready);
    chk_status(tag);
  endtask

  initial begin
    int            rc, p0, a0;
    logic          w, r, seen;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    #3;
    chk("rst_req", bus_req, 1'b0);
    chk("rst_ready", static_ready, 1'b0);
    chk("rst_rdata", static_rdata, '0);
    chk("rst_bus", {bus_we, bus_addr, bus_wdata}, '0);
    chk_status("rst");
    #19 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    do_txn("wr",   1'b1, 1'b0, 20'h00600, 32'h3, 1, 32'h0, rc);
    do_txn("rd",   1'b0, 1'b1, 20'h00002, 32'h0, 1, 32'h1357_9876, rc);
    chk("rd_rdy_within8", (rc >= 1 && rc <= 8), 1'b1);
    do_txn("tmo",  1'b0, 1'b1, 20'h001FF, 32'h0, 1000, 32'h0, rc);
    do_txn("ill",  1'b1, 1'b1, 20'h00500, 32'h1, 1, 32'h0, rc);
    do_txn("none", 1'b0, 1'b0, 20'h00480, 32'h1, 1, 32'h0, rc);
    do_txn("ack0", 1'b0, 1'b1, 20'h00010, 32'h0, 0, 32'hA5A5_0F0F, rc);
    do_txn("ack11", 1'b0, 1'b1, 20'h00011, 32'h0, 11, 32'h0BAD_F00D, rc);

    // Back-to-back: second toggle queues, third during the stall is dropped.
    static_wen = 1'b1; static_ren = 1'b0; static_addr = 20'h00500; static_wdata = 32'h1;
    rsp_delay = 5;
    p0 = pulses; a0 = obs_acks;
    repeat (4) @(negedge clk);
    scan_id = ~scan_id;
    repeat (3) @(negedge clk);
    scan_id = ~scan_id;
    repeat (3) @(negedge clk);
    scan_id = ~scan_id;
    repeat (40) @(negedge clk);
    st_ov = 1'b1;
    st_cnt = st_cnt + 5'd2;
    chk("b2b_pulses", pulses - p0, 2);
    chk("b2b_acks", obs_acks - a0, 2);
    chk("b2b_len", last_len, 6);
    chk("b2b_addr", obs_addr, 20'h00500);
    chk("b2b_ready", static_ready, exp_ready);
    chk_status("b2b");

`ifdef SCAN_BRIDGE_STATUS_EN
    do_txn("clr", 1'b1, 1'b0, 20'h00700, 32'h1, 1, 32'h0, rc);
`endif

    for (int k = 0; k < 24; k++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      a = AW'($urandom);
      if (a == 20'h00700) a = 20'h00701;
      d = $urandom;
      do_txn($sformatf("rnd%0d", k), w, r, a, d, int'($urandom_range(0, 14)), $urandom, rc);
    end

    // Reset in the middle of a stalled read.
    static_wen = 1'b0; static_ren = 1'b1; static_addr = 20'h00123; rsp_delay = 200;
    repeat (4) @(negedge clk);
    scan_id = ~scan_id;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus_req;
    end
    chk("mid_req_seen", seen, 1'b1);
    #2 rst_n = 1'b0;
    scan_id = 1'b0;
    #1;
    chk("mid_rst_req", bus_req, 1'b0);
    chk("mid_rst_ready", static_ready, 1'b0);
    chk("mid_rst_rdata", static_rdata, '0);
    chk("mid_rst_bus", {bus_we, bus_addr, bus_wdata}, '0);
    exp_rdata = '0; exp_ready = 1'b0;
    st_to = 1'b0; st_il = 1'b0; st_ov = 1'b0; st_cnt = '0;
    chk_status("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    p0 = pulses;
    repeat (30) @(negedge clk);
    chk("post_rst_quiet", pulses - p0, 0);
    do_txn("post_rd", 1'b0, 1'b1, 20'h00040, 32'h0, 2, 32'hCAFE_1234, rc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
